// File: rtl/mem_bank_if.sv
// Command/data bus between the SDRAM controller and mem_bank_core.
// The controller is the master; the bank core is the slave.
interface mem_bank_if #(
    parameter int NUM_BANKS      = 4,
    parameter int ROW_ADDR_DEPTH = 8,
    parameter int COL_ADDR_DEPTH = 6,
    parameter int MEM_ELEM_DEPTH = 32
);
    localparam int BW = $clog2(NUM_BANKS);

    logic [2:0]                  cmd;
    logic [BW-1:0]               bank_addr;
    logic [ROW_ADDR_DEPTH-1:0]   row_addr;
    logic [COL_ADDR_DEPTH-1:0]   col_addr;
    logic [MEM_ELEM_DEPTH-1:0]   wr_data;
    logic [MEM_ELEM_DEPTH/8-1:0] wr_mask;
    logic [MEM_ELEM_DEPTH-1:0]   rd_data;
    logic                        rd_valid;
    logic                        cmd_err;
    logic [NUM_BANKS-1:0]        bank_open;
    logic [NUM_BANKS-1:0]        bank_busy;

    modport master (
        output cmd, bank_addr, row_addr, col_addr, wr_data, wr_mask,
        input  rd_data, rd_valid, cmd_err, bank_open, bank_busy
    );

    modport slave (
        input  cmd, bank_addr, row_addr, col_addr, wr_data, wr_mask,
        output rd_data, rd_valid, cmd_err, bank_open, bank_busy
    );
endinterface

// File: rtl/mem_bank_core.sv
// Multi-bank SDRAM storage core: per-bank row array, row buffer and
// a timing state machine enforcing activate and precharge delays.
module mem_bank_core #(
    parameter int NUM_BANKS      = 4,
    parameter int ROW_ADDR_DEPTH = 8,
    parameter int COL_ADDR_DEPTH = 6,
    parameter int MEM_ELEM_DEPTH = 32,
    parameter int T_RCD          = 2,
    parameter int T_RP           = 2
) (
    input  logic     clk,
    input  logic     reset,
    mem_bank_if.slave bus
);
    localparam int BW   = $clog2(NUM_BANKS);
    localparam int ROWS = 2 ** ROW_ADDR_DEPTH;
    localparam int COLS = 2 ** COL_ADDR_DEPTH;
    localparam int W    = MEM_ELEM_DEPTH;
    localparam int MW   = W / 8;
    localparam int RW   = COLS * W;
    localparam int XW   = $clog2(RW);
    localparam int IW   = BW + ROW_ADDR_DEPTH;
    localparam int TMAX = (T_RCD > T_RP) ? T_RCD : T_RP;
    localparam int CW   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVATING,
        ACTIVE,
        PRECHARGING
    } bank_state_t;

    typedef logic [RW-1:0] row_t;

    bank_state_t [NUM_BANKS-1:0]               state;
    bank_state_t [NUM_BANKS-1:0]               nxt_state;
    logic [NUM_BANKS-1:0][CW-1:0]              cnt;
    logic [NUM_BANKS-1:0][CW-1:0]              nxt_cnt;
    logic [NUM_BANKS-1:0][ROW_ADDR_DEPTH-1:0]  open_row;
    logic [NUM_BANKS-1:0][RW-1:0]              buffer;

    // Array contents are not reset; a cleared row_vld bit makes the
    // row read back as all-ones, which is the post-reset image.
    row_t                  mem_array [NUM_BANKS*ROWS];
    logic [NUM_BANKS*ROWS-1:0] row_vld;

    logic [BW-1:0]         ba;
    logic [IW-1:0]         act_idx;
    logic [IW-1:0]         pre_idx;
    logic [XW-1:0]         col_base;
    logic [W-1:0]          rd_elem;
    logic [W-1:0]          wr_elem;
    logic [NUM_BANKS-1:0]  can_open;
    logic [NUM_BANKS-1:0]  can_acc;
    logic [NUM_BANKS-1:0]  nxt_open;
    logic [NUM_BANKS-1:0]  nxt_busy;
    logic is_act, is_pre, is_rd, is_wr, is_ill;
    logic acc_act, acc_pre, acc_rd, acc_wr, err;

    assign ba       = bus.bank_addr;
    assign act_idx  = {ba, bus.row_addr};
    assign pre_idx  = {ba, open_row[ba]};
    assign col_base = XW'(bus.col_addr) * XW'(W);

    assign is_act = (bus.cmd == 3'd1);
    assign is_pre = (bus.cmd == 3'd2);
    assign is_rd  = (bus.cmd == 3'd3);
    assign is_wr  = (bus.cmd == 3'd4);
    assign is_ill = (bus.cmd > 3'd4);

    // A bank whose timer expires this cycle already behaves as the
    // destination state, so accesses land exactly T_RCD/T_RP after.
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            can_open[b] = (state[b] == IDLE) ||
                          (state[b] == PRECHARGING && cnt[b] == '0);
            can_acc[b]  = (state[b] == ACTIVE) ||
                          (state[b] == ACTIVATING && cnt[b] == '0);
        end
    end

    // Command acceptance and error classification for the target bank.
    always_comb begin
        acc_act = is_act && can_open[ba];
        acc_pre = is_pre && can_acc[ba];
        acc_rd  = is_rd && can_acc[ba];
        acc_wr  = is_wr && can_acc[ba];
        err     = is_ill ||
                  (is_act && !can_open[ba]) ||
                  (is_pre && !can_acc[ba] && !can_open[ba]) ||
                  ((is_rd || is_wr) && !can_acc[ba]);
    end

    // Column read and byte-masked merge on the target row buffer.
    always_comb begin
        rd_elem = buffer[ba][col_base +: W];
        wr_elem = rd_elem;
        for (int i = 0; i < MW; i++) begin
            if (bus.wr_mask[i]) begin
                wr_elem[i*8 +: 8] = bus.wr_data[i*8 +: 8];
            end
        end
    end

    // Per-bank next state: timers count down, then the command applies.
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            nxt_state[b] = state[b];
            nxt_cnt[b]   = cnt[b];
            unique case (state[b])
                ACTIVATING: begin
                    if (cnt[b] == '0) nxt_state[b] = ACTIVE;
                    else              nxt_cnt[b] = cnt[b] - 1'b1;
                end
                PRECHARGING: begin
                    if (cnt[b] == '0) nxt_state[b] = IDLE;
                    else              nxt_cnt[b] = cnt[b] - 1'b1;
                end
                default: ;
            endcase
            if (BW'(b) == ba) begin
                if (acc_act) begin
                    nxt_state[b] = ACTIVATING;
                    nxt_cnt[b]   = CW'(T_RCD - 1);
                end
                if (acc_pre) begin
                    nxt_state[b] = PRECHARGING;
                    nxt_cnt[b]   = CW'(T_RP - 1);
                end
            end
            nxt_open[b] = (nxt_state[b] == ACTIVE);
            nxt_busy[b] = (nxt_state[b] == ACTIVATING) ||
                          (nxt_state[b] == PRECHARGING);
        end
    end

    // Row writeback into the array on an accepted precharge.
    always_ff @(posedge clk) begin
        if (reset && acc_pre) begin
            mem_array[pre_idx] <= buffer[ba];
        end
    end

    // Bank state, row buffers and registered bus outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= {NUM_BANKS{IDLE}};
            cnt           <= '0;
            open_row      <= '0;
            buffer        <= '1;
            row_vld       <= '0;
            bus.rd_data   <= '0;
            bus.rd_valid  <= 1'b0;
            bus.cmd_err   <= 1'b0;
            bus.bank_open <= '0;
            bus.bank_busy <= '0;
        end else begin
            state         <= nxt_state;
            cnt           <= nxt_cnt;
            bus.bank_open <= nxt_open;
            bus.bank_busy <= nxt_busy;
            if (acc_act) begin
                open_row[ba] <= bus.row_addr;
                buffer[ba]   <= row_vld[act_idx] ?
                                mem_array[act_idx] : '1;
            end
            if (acc_pre) row_vld[pre_idx] <= 1'b1;
            if (acc_wr) buffer[ba][col_base +: W] <= wr_elem;
            if (acc_rd) bus.rd_data <= rd_elem;
            bus.rd_valid <= acc_rd;
            bus.cmd_err  <= err;
        end
    end
endmodule

// File: tb/tb_mem_bank_core.sv
// Bench for mem_bank_core: directed vector table, corner sequences
// and random traffic against a timestamp-based reference model.
module tb_mem_bank_core;
    localparam int NB    = 4;
    localparam int T_RCD = 2;
    localparam int T_RP  = 2;

    logic clk;
    logic reset;

    mem_bank_if #(
        .NUM_BANKS(NB), .ROW_ADDR_DEPTH(8),
        .COL_ADDR_DEPTH(6), .MEM_ELEM_DEPTH(32)
    ) bus ();

    mem_bank_core #(
        .NUM_BANKS(NB), .ROW_ADDR_DEPTH(8), .COL_ADDR_DEPTH(6),
        .MEM_ELEM_DEPTH(32), .T_RCD(T_RCD), .T_RP(T_RP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  cmd;
        int          bank;
        int          row;
        int          col;
        logic [31:0] data;
        logic [3:0]  mask;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t tbl[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: each bank remembers its last accepted ACT/PRE
    // and when it happened; legality follows from elapsed cycles.
    int          mk   [NB];
    int          mt   [NB];
    int          mrow [NB];
    logic [31:0] mbuf [NB][64];
    logic [31:0] mmem [int];
    logic [31:0] m_rd;
    logic        e_valid;
    logic        e_err;
    logic [3:0]  e_open;
    logic [3:0]  e_busy;

    function automatic int key(int b, int r, int c);
        return (b << 14) | (r << 6) | c;
    endfunction

    function automatic bit can_open(int b);
        return mk[b] == 0 || (mk[b] == 2 && cyc >= mt[b] + T_RP);
    endfunction

    function automatic bit can_acc(int b);
        return mk[b] == 1 && cyc >= mt[b] + T_RCD;
    endfunction

    task automatic model_reset();
        for (int b = 0; b < NB; b++) begin
            mk[b] = 0;
            mt[b] = 0;
            mrow[b] = 0;
            for (int c = 0; c < 64; c++) mbuf[b][c] = 32'hFFFF_FFFF;
        end
        mmem.delete();
        m_rd = 32'h0;
    endtask

    task automatic model_step(input logic [2:0] c, input int b,
                              input int r, input int col,
                              input logic [31:0] d, input logic [3:0] m);
        int n;
        e_err = 1'b0;
        e_valid = 1'b0;
        case (c)
            3'd0: ;
            3'd1: begin
                if (can_open(b)) begin
                    mk[b] = 1;
                    mt[b] = cyc;
                    mrow[b] = r;
                    for (int k = 0; k < 64; k++) begin
                        if (mmem.exists(key(b, r, k)))
                            mbuf[b][k] = mmem[key(b, r, k)];
                        else
                            mbuf[b][k] = 32'hFFFF_FFFF;
                    end
                end else e_err = 1'b1;
            end
            3'd2: begin
                if (can_acc(b)) begin
                    for (int k = 0; k < 64; k++)
                        mmem[key(b, mrow[b], k)] = mbuf[b][k];
                    mk[b] = 2;
                    mt[b] = cyc;
                end else if (!can_open(b)) e_err = 1'b1;
            end
            3'd3: begin
                if (can_acc(b)) begin
                    e_valid = 1'b1;
                    m_rd = mbuf[b][col];
                end else e_err = 1'b1;
            end
            3'd4: begin
                if (can_acc(b)) begin
                    for (int i = 0; i < 4; i++)
                        if (m[i]) mbuf[b][col][i*8 +: 8] = d[i*8 +: 8];
                end else e_err = 1'b1;
            end
            default: e_err = 1'b1;
        endcase
        n = cyc + 1;
        for (int k = 0; k < NB; k++) begin
            e_open[k] = (mk[k] == 1) && (n >= mt[k] + T_RCD + 1);
            e_busy[k] = ((mk[k] == 1) && (n <= mt[k] + T_RCD)) ||
                        ((mk[k] == 2) && (n <= mt[k] + T_RP));
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got %h expected %h",
                     name, cyc, got, exp);
        end
    endtask

    task automatic apply(input logic [2:0] c, input int b, input int r,
                         input int col, input logic [31:0] d,
                         input logic [3:0] m);
        bus.cmd       = c;
        bus.bank_addr = 2'(b);
        bus.row_addr  = 8'(r);
        bus.col_addr  = 6'(col);
        bus.wr_data   = d;
        bus.wr_mask   = m;
        @(posedge clk);
        #1;
        model_step(c, b, r, col, d, m);
        chk("rd_valid", 32'(bus.rd_valid), 32'(e_valid));
        chk("cmd_err", 32'(bus.cmd_err), 32'(e_err));
        chk("rd_data", bus.rd_data, m_rd);
        chk("bank_open", 32'(bus.bank_open), 32'(e_open));
        chk("bank_busy", 32'(bus.bank_busy), 32'(e_busy));
        cyc++;
    endtask

    task automatic do_reset();
        reset   = 1'b0;
        bus.cmd = 3'd0;
        @(posedge clk);
        #1;
        chk("rst_rd_data", bus.rd_data, 32'h0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'h0);
        chk("rst_cmd_err", 32'(bus.cmd_err), 32'h0);
        chk("rst_bank_open", 32'(bus.bank_open), 32'h0);
        chk("rst_bank_busy", 32'(bus.bank_busy), 32'h0);
        reset = 1'b1;
        model_reset();
        cyc++;
    endtask

    task automatic add(input logic [2:0] c, input int b, input int r,
                       input int col, input logic [31:0] d,
                       input logic [3:0] m, input logic ev,
                       input logic [31:0] ed, input logic ee);
        vec_t v;
        v.cmd = c; v.bank = b; v.row = r; v.col = col;
        v.data = d; v.mask = m;
        v.exp_valid = ev; v.exp_data = ed; v.exp_err = ee;
        tbl.push_back(v);
    endtask

    initial begin
        logic [31:0] ones;
        logic [31:0] pat;
        ones = 32'hFFFF_FFFF;
        pat  = 32'hFF34_FF78;
        reset         = 1'b0;
        bus.cmd       = 3'd0;
        bus.bank_addr = '0;
        bus.row_addr  = '0;
        bus.col_addr  = '0;
        bus.wr_data   = '0;
        bus.wr_mask   = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        add(1, 0, 5, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(3, 0, 0, 3, 0, 0, 1, ones, 0);
        add(1, 1, 7, 0, 0, 0, 0, ones, 0);
        add(0, 0, 0, 0, 0, 0, 0, ones, 0);
        add(4, 1, 0, 0, 32'h1234_5678, 4'b0101, 0, ones, 0);
        add(3, 1, 0, 0, 0, 0, 1, pat, 0);
        add(2, 1, 0, 0, 0, 0, 0, pat, 0);
        add(0, 0, 0, 0, 0, 0, 0, pat, 0);
        add(1, 1, 7, 0, 0, 0, 0, pat, 0);
        add(0, 0, 0, 0, 0, 0, 0, pat, 0);
        add(3, 1, 0, 0, 0, 0, 1, pat, 0);
        add(2, 1, 0, 0, 0, 0, 0, pat, 0);
        add(0, 0, 0, 0, 0, 0, 0, pat, 0);
        add(1, 1, 8, 0, 0, 0, 0, pat, 0);
        add(0, 0, 0, 0, 0, 0, 0, pat, 0);
        add(3, 1, 0, 0, 0, 0, 1, ones, 0);
        add(1, 2, 0, 0, 0, 0, 0, ones, 0);
        add(3, 2, 0, 0, 0, 0, 0, ones, 1);
        add(0, 0, 0, 0, 0, 0, 0, ones, 0);
        add(1, 2, 1, 0, 0, 0, 0, ones, 1);
        add(2, 2, 0, 0, 0, 0, 0, ones, 0);
        add(1, 2, 1, 0, 0, 0, 0, ones, 1);
        add(6, 0, 0, 0, 0, 0, 0, ones, 1);
        add(3, 1, 0, 0, 0, 0, 1, ones, 0);
        add(2, 0, 0, 0, 0, 0, 0, ones, 0);
        add(2, 1, 0, 0, 0, 0, 0, ones, 0);
        add(1, 0, 1, 0, 0, 0, 0, ones, 0);
        add(1, 2, 9, 0, 0, 0, 0, ones, 0);
        add(4, 0, 0, 2, 32'hA, 4'hF, 0, ones, 0);
        add(4, 2, 0, 2, 32'hB, 4'hF, 0, ones, 0);
        add(3, 0, 0, 2, 0, 0, 1, 32'hA, 0);
        add(3, 2, 0, 2, 0, 0, 1, 32'hB, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].cmd, tbl[i].bank, tbl[i].row, tbl[i].col,
                  tbl[i].data, tbl[i].mask);
            chk("tbl_valid", 32'(bus.rd_valid), 32'(tbl[i].exp_valid));
            chk("tbl_data", bus.rd_data, tbl[i].exp_data);
            chk("tbl_err", 32'(bus.cmd_err), 32'(tbl[i].exp_err));
        end
        chk("interleave_open", 32'(bus.bank_open), 32'h5);

        apply(1, 3, 4, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 0);
        apply(4, 3, 0, 1, 32'hDEAD_BEEF, 4'hF);
        apply(2, 3, 0, 0, 0, 0);
        chk("pre_busy", 32'(bus.bank_busy[3]), 32'h1);
        do_reset();
        apply(3, 0, 0, 2, 0, 0);
        chk("rd_after_reset_err", 32'(bus.cmd_err), 32'h1);
        apply(1, 3, 4, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 0);
        apply(3, 3, 0, 1, 0, 0);
        chk("reset_ones", bus.rd_data, ones);

        for (int i = 0; i < 3000; i++) begin
            int sel;
            logic [2:0] c;
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
                continue;
            end
            sel = $urandom_range(0, 15);
            if (sel < 3)       c = 3'd0;
            else if (sel < 6)  c = 3'd1;
            else if (sel < 8)  c = 3'd2;
            else if (sel < 11) c = 3'd3;
            else if (sel < 15) c = 3'd4;
            else               c = 3'(5 + $urandom_range(0, 2));
            apply(c, $urandom_range(0, NB - 1), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom,
                  4'($urandom_range(0, 15)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
